// File: rtl/sample_pkg.sv
// ----------------------------------------------------------------------------
// sample_pkg
//   Shared definitions for the sample accumulator control block:
//     - default sample and accumulator widths
//     - FSM state encoding
//     - packed control-output bundle and its Moore decode from a state
// ----------------------------------------------------------------------------
package sample_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SUM_W_DEF  = 26;   // 1000 * (2^16 - 1) fits without overflow

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        COUNT = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    typedef struct packed {
        logic modwait;
        logic cnt_up;
        logic clear;
        logic done;
        logic err;
    } ctrl_t;

    // Moore output decode. The top evaluates this on the next state so the
    // outputs come straight out of flops in the same cycle as the state.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ACCUM: c.modwait = 1'b1;
            COUNT: begin
                c.modwait = 1'b1;
                c.cnt_up  = 1'b1;
            end
            CHECK: c.modwait = 1'b1;
            DONE: begin
                c.modwait = 1'b1;
                c.done    = 1'b1;
                c.clear   = 1'b1;
            end
            ERR: begin
                c.err   = 1'b1;
                c.clear = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// ----------------------------------------------------------------------------
// rise_edge_det
//   Rising-edge detector on a level input.
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous active-high reset
//     d      in  level to watch
//     rise   out combinational: d is 1 now and was 0 last cycle
//   The history flop resets to 1 so a level already high when reset is
//   released is not taken as an edge.
// ----------------------------------------------------------------------------
module rise_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/sample_accum_ctrl.sv
// ----------------------------------------------------------------------------
// sample_accum_ctrl
//   Upstream control/datapath stage for the 1000-sample counter. Takes samples
//   from the ADC-side source on a data_ready rising edge, accumulates them,
//   pulses cnt_up to the sample counter, and publishes the sum once the
//   counter reports 1000 samples. Accumulator overflow parks the block in ERR.
//   Ports:
//     clk            in   system clock
//     reset          in   synchronous active-high reset
//     data_ready     in   source has a sample (rising edge accepted)
//     data_in        in   DATA_W unsigned sample
//     one_k_samples  in   registered "count == 1000" flag from the counter
//     modwait        out  busy; source must hold off
//     cnt_up         out  one-cycle increment pulse to the counter
//     clear          out  counter clear (pulse in DONE, held in ERR)
//     done           out  one-cycle pulse, sum_out carries a full sum
//     err            out  accumulator overflow, held until next sample
//     sum_out        out  SUM_W last completed sum
// ----------------------------------------------------------------------------
module sample_accum_ctrl
    import sample_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              one_k_samples,
    output logic              modwait,
    output logic              cnt_up,
    output logic              clear,
    output logic              done,
    output logic              err,
    output logic [SUM_W-1:0]  sum_out
);

    logic rise;

    rise_edge_det u_rise (
        .clk   (clk),
        .reset (reset),
        .d     (data_ready),
        .rise  (rise)
    );

    state_t              state_q,   state_d;
    ctrl_t               ctrl_q,    ctrl_d;
    logic [DATA_W-1:0]   sample_q,  sample_d;
    logic [SUM_W-1:0]    sum_q,     sum_d;
    logic [SUM_W-1:0]    sum_out_q, sum_out_d;
    logic [SUM_W:0]      add_w;

    // One extra bit on the adder; its MSB is the overflow carry.
    assign add_w = {1'b0, sum_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, sample_q};

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        sum_d     = sum_q;
        sum_out_d = sum_out_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    sample_d = data_in;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                // On overflow the sum is left alone; ERR wipes it.
                if (add_w[SUM_W]) begin
                    state_d = ERR;
                end else begin
                    sum_d   = add_w[SUM_W-1:0];
                    state_d = COUNT;
                end
            end
            COUNT: state_d = CHECK;
            CHECK: begin
                if (one_k_samples) begin
                    // Publish on entry to DONE so sum_out is already valid
                    // while the done pulse is high.
                    sum_out_d = sum_q;
                    state_d   = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                sum_d   = '0;
                state_d = IDLE;
            end
            ERR: begin
                sum_d = '0;
                if (rise) begin
                    sample_d = data_in;
                    state_d  = ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase

        ctrl_d = ctrl_for(state_d);
    end

    // State and registered Moore outputs; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            sample_q  <= '0;
            sum_q     <= '0;
            sum_out_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            sample_q  <= sample_d;
            sum_q     <= sum_d;
            sum_out_q <= sum_out_d;
        end
    end

    assign modwait = ctrl_q.modwait;
    assign cnt_up  = ctrl_q.cnt_up;
    assign clear   = ctrl_q.clear;
    assign done    = ctrl_q.done;
    assign err     = ctrl_q.err;
    assign sum_out = sum_out_q;

endmodule

// File: tb/tb_sample_accum_ctrl.sv
module tb_sample_accum_ctrl;
    import sample_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default widths (SUM_W = 26)
    logic        rst_a, dr_a, onek_a, mw_a, cu_a, clr_a, dn_a, er_a;
    logic [15:0] din_a;
    logic [25:0] so_a;
    // DUT B: narrow accumulator (SUM_W = 18) for overflow
    logic        rst_b, dr_b, onek_b, mw_b, cu_b, clr_b, dn_b, er_b;
    logic [15:0] din_b;
    logic [17:0] so_b;

    sample_accum_ctrl #(.DATA_W(16), .SUM_W(26)) dut_a (
        .clk(clk), .reset(rst_a), .data_ready(dr_a), .data_in(din_a),
        .one_k_samples(onek_a), .modwait(mw_a), .cnt_up(cu_a), .clear(clr_a),
        .done(dn_a), .err(er_a), .sum_out(so_a)
    );

    sample_accum_ctrl #(.DATA_W(16), .SUM_W(18)) dut_b (
        .clk(clk), .reset(rst_b), .data_ready(dr_b), .data_in(din_b),
        .one_k_samples(onek_b), .modwait(mw_b), .cnt_up(cu_b), .clear(clr_b),
        .done(dn_b), .err(er_b), .sum_out(so_b)
    );

    // Behavioural 1000-rollover sample counters with registered flag.
    int kcnt_a = 0, kcnt_b = 0;
    always @(posedge clk) begin
        if (rst_a || clr_a) begin
            kcnt_a <= 0;
            onek_a <= 1'b0;
        end else if (cu_a) begin
            kcnt_a <= (kcnt_a == 1000) ? 1 : kcnt_a + 1;
            onek_a <= ((kcnt_a == 1000) ? 1 : kcnt_a + 1) == 1000;
        end
    end
    always @(posedge clk) begin
        if (rst_b || clr_b) begin
            kcnt_b <= 0;
            onek_b <= 1'b0;
        end else if (cu_b) begin
            kcnt_b <= (kcnt_b == 1000) ? 1 : kcnt_b + 1;
            onek_b <= ((kcnt_b == 1000) ? 1 : kcnt_b + 1) == 1000;
        end
    end

    // Pulse monitors
    int          cu_cnt_a = 0, cu_cnt_b = 0, dn_cnt_a = 0, dn_noclr_a = 0, dn_cnt_b = 0;
    logic [25:0] so_at_done = '0;
    always @(negedge clk) begin
        if (cu_a === 1'b1) cu_cnt_a++;
        if (cu_b === 1'b1) cu_cnt_b++;
        if (dn_b === 1'b1) dn_cnt_b++;
        if (dn_a === 1'b1) begin
            dn_cnt_a++;
            so_at_done = so_a;
            if (clr_a !== 1'b1) dn_noclr_a++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int tmo   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample: rise at the next negedge, drop after one cycle, then wait
    // (bounded) until the selected DUT is no longer busy.
    task automatic send(input bit b, input logic [15:0] d);
        bit ok;
        @(negedge clk);
        if (!b) begin din_a = d; dr_a = 1'b1; end
        else    begin din_b = d; dr_b = 1'b1; end
        @(negedge clk);
        if (!b) dr_a = 1'b0; else dr_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((b ? mw_b : mw_a) == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) tmo++;
    endtask

    int base_cu, base_dn;

    initial begin
        // 1: reset with data_ready held high, released still high
        rst_a = 1'b1; rst_b = 1'b1;
        dr_a = 1'b1; dr_b = 1'b0;
        din_a = 16'h1234; din_b = 16'h0000;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_modwait", 64'(mw_a), 64'd0);
        check("rst_cnt_up",  64'(cu_a), 64'd0);
        check("rst_clear",   64'(clr_a), 64'd0);
        check("rst_done",    64'(dn_a), 64'd0);
        check("rst_err",     64'(er_a), 64'd0);
        check("rst_sum_out", 64'(so_a), 64'd0);
        check("rst_state",   64'(dut_a.state_q), 64'(IDLE));
        check("rst_nocapt",  64'(dut_a.sample_q), 64'd0);
        check("rst_cu_cnt",  64'(cu_cnt_a), 64'd0);

        // 2: single sample 5, cycle-by-cycle latency
        dr_a = 1'b0;
        @(negedge clk);
        din_a = 16'h0005; dr_a = 1'b1;
        @(negedge clk);                 // ACCUM
        dr_a = 1'b0;
        check("t2_c1_modwait", 64'(mw_a), 64'd1);
        check("t2_c1_cnt_up",  64'(cu_a), 64'd0);
        @(negedge clk);                 // COUNT
        check("t2_c2_modwait", 64'(mw_a), 64'd1);
        check("t2_c2_cnt_up",  64'(cu_a), 64'd1);
        @(negedge clk);                 // CHECK
        check("t2_c3_modwait", 64'(mw_a), 64'd1);
        check("t2_c3_cnt_up",  64'(cu_a), 64'd0);
        check("t2_c3_state",   64'(dut_a.state_q), 64'(CHECK));
        @(negedge clk);                 // IDLE
        check("t2_c4_modwait", 64'(mw_a), 64'd0);
        check("t2_c4_done",    64'(dn_a), 64'd0);
        check("t2_sum",        64'(dut_a.sum_q), 64'd5);
        base_cu = cu_cnt_a;

        // 5: second rise during modwait is dropped, held level does not retrigger
        din_a = 16'd10; dr_a = 1'b1;    // rise seen at next posedge
        @(negedge clk);
        dr_a = 1'b0;
        @(negedge clk);
        din_a = 16'd20; dr_a = 1'b1;    // rise lands while in COUNT
        repeat (4) @(negedge clk);
        check("t5_modwait", 64'(mw_a), 64'd0);
        check("t5_sum",     64'(dut_a.sum_q), 64'd15);
        check("t5_cu_once", 64'(cu_cnt_a - base_cu), 64'd1);
        check("t5_state",   64'(dut_a.state_q), 64'(IDLE));
        dr_a = 1'b0;
        @(negedge clk);

        // 6: reset while in COUNT
        din_a = 16'd1; dr_a = 1'b1;
        @(negedge clk);                 // ACCUM
        dr_a = 1'b0;
        @(negedge clk);                 // COUNT
        check("t6_in_count", 64'(cu_a), 64'd1);
        rst_a = 1'b1;
        @(negedge clk);
        check("t6_cnt_up",  64'(cu_a), 64'd0);
        check("t6_modwait", 64'(mw_a), 64'd0);
        check("t6_sum_out", 64'(so_a), 64'd0);
        check("t6_state",   64'(dut_a.state_q), 64'(IDLE));
        check("t6_sum",     64'(dut_a.sum_q), 64'd0);
        rst_a = 1'b0;
        @(negedge clk);

        // 3: 1000 samples of FFFF
        base_dn = dn_cnt_a;
        for (int k = 0; k < 1000; k++) send(1'b0, 16'hFFFF);
        @(negedge clk);
        check("t3_done_once",   64'(dn_cnt_a - base_dn), 64'd1);
        check("t3_done_clear",  64'(dn_noclr_a), 64'd0);
        check("t3_sum_at_done", 64'(so_at_done), 64'd65535000);
        check("t3_sum_out",     64'(so_a), 64'd65535000);
        check("t3_sum_cleared", 64'(dut_a.sum_q), 64'd0);
        send(1'b0, 16'h0007);
        @(negedge clk);
        check("t3_restart_sum", 64'(dut_a.sum_q), 64'd7);
        check("t3_sum_out_hold", 64'(so_a), 64'd65535000);
        check("t3_no_extra_done", 64'(dn_cnt_a - base_dn), 64'd1);

        // 4: overflow on the 18-bit instance
        base_cu = cu_cnt_b;
        for (int k = 0; k < 4; k++) send(1'b1, 16'hFFFF);
        check("t4_sum4",  64'(dut_b.sum_q), 64'd262140);
        check("t4_err0",  64'(er_b), 64'd0);
        check("t4_cu4",   64'(cu_cnt_b - base_cu), 64'd4);
        send(1'b1, 16'hFFFF);
        check("t4_err",     64'(er_b), 64'd1);
        check("t4_clear",   64'(clr_b), 64'd1);
        check("t4_modwait", 64'(mw_b), 64'd0);
        check("t4_state",   64'(dut_b.state_q), 64'(ERR));
        @(negedge clk);
        check("t4_no_cu",    64'(cu_cnt_b - base_cu), 64'd4);
        check("t4_clear_held", 64'(clr_b), 64'd1);
        check("t4_sum_wiped", 64'(dut_b.sum_q), 64'd0);
        send(1'b1, 16'h0003);
        check("t4_err_drop", 64'(er_b), 64'd0);
        check("t4_sum3",     64'(dut_b.sum_q), 64'd3);
        check("t4_cu5",      64'(cu_cnt_b - base_cu), 64'd5);
        check("t4_no_done",  64'(dn_cnt_b), 64'd0);

        check("timeouts", 64'(tmo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
